// File: rtl/key_pkg.sv
// key_pkg -- definitions shared by the key scanner.
//   NUM_KEYS        number of switch channels
//   KEY_IDX_W       width of a channel index
//   EVT_FIFO_DEPTH  entries in the event FIFO
//   key_evt_t       event record {level, idx}
//   lowest_set()    index of the lowest set bit in a channel mask
package key_pkg;

  localparam int NUM_KEYS       = 16;
  localparam int KEY_IDX_W      = 4;
  localparam int EVT_FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W     = 2;
  localparam int FIFO_CNT_W     = 3;

  typedef struct packed {
    logic                 level;
    logic [KEY_IDX_W-1:0] idx;
  } key_evt_t;

  // Priority pick: scanning from the top down, the last hit wins,
  // so the lowest-index set bit is returned. Returns 0 for an empty mask.
  function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- one switch channel: 2-flop synchronizer plus debouncer.
//   clk, rst_n  clock / asynchronous active-low reset
//   sw_async    raw switch level
//   stable      debounced level
//   toggle      high in the cycle whose rising edge flips 'stable'
// The counter runs while the synchronized level differs from 'stable' and
// clears as soon as they agree, so any glitch restarts the count. 'stable'
// flips on the edge where DEBOUNCE_CYCLES consecutive differing samples have
// been seen (counter already at DEBOUNCE_CYCLES-1 and still differing).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic stable,
  output logic toggle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = sw_async;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    toggle   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      toggle   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_scan.sv
// key_scan -- 16-channel debounced switch scanner with an event FIFO.
//   clk, rst_n  clock / asynchronous active-low reset
//   sw          raw switch levels, bit i = channel i
//   sw_stable   debounced levels
//   evt_valid   event available at FIFO head
//   evt_ready   consumer accepts head event
//   evt_data    head event: bit 4 = level, bits 3:0 = channel
//   evt_count   FIFO occupancy 0..4
// Build option: KEY_SCAN_RELEASE_EVT_EN queues both press and release
// events; without it only 0->1 transitions queue events (level always 1).
//
// Handshake: the head entry transfers on every rising edge where
// evt_valid && evt_ready; evt_data is meaningful only while evt_valid is
// high and stays put until accepted. evt_ready with an empty FIFO is ignored.
module key_scan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   sw,
  output logic [NUM_KEYS-1:0]   sw_stable,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_IDX_W:0]    evt_data,
  output logic [FIFO_CNT_W-1:0] evt_count
);

  logic [NUM_KEYS-1:0] stable_w;
  logic [NUM_KEYS-1:0] toggle_w;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_async (sw[g]),
      .stable   (stable_w[g]),
      .toggle   (toggle_w[g])
    );
  end

  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  key_evt_t              mem_q [EVT_FIFO_DEPTH];
  key_evt_t              mem_d [EVT_FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  logic                  pop, push;
  logic [KEY_IDX_W-1:0]  scan_idx;
  logic [NUM_KEYS-1:0]   pend_set;
  logic                  push_level;

  always_comb begin
    scan_idx = lowest_set(pending_q);
`ifdef KEY_SCAN_RELEASE_EVT_EN
    pend_set   = toggle_w;
    // Level is read at push time, so a channel that flipped twice while
    // waiting reports where it is now.
    push_level = stable_w[scan_idx];
`else
    // stable_w is the pre-toggle level: 0 means this is a 0->1 transition.
    pend_set   = toggle_w & ~stable_w;
    push_level = 1'b1;
`endif
  end

  always_comb begin
    pop  = (count_q != '0) && evt_ready;
    // A full FIFO still accepts a push when the head leaves this cycle.
    push = (pending_q != '0) &&
           ((count_q != FIFO_CNT_W'(EVT_FIFO_DEPTH)) || pop);

    pending_d = pending_q;
    mem_d     = mem_q;
    if (push) begin
      pending_d[scan_idx]    = 1'b0;
      mem_d[wr_ptr_q].level  = push_level;
      mem_d[wr_ptr_q].idx    = scan_idx;
    end
    // A new toggle wins over the clear of the entry just pushed.
    pending_d = pending_d | pend_set;

    wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(push);
    rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < EVT_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < EVT_FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign sw_stable = stable_w;
  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign evt_count = count_q;

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan -- directed and randomized checks of key_scan (DEBOUNCE_CYCLES=8)
// against a window-based behavioural model of debounce plus an event queue.
module tb_key_scan;

  localparam int DC = 8;
`ifdef KEY_SCAN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        evt_ready = 1'b0;
  logic [15:0] sw_stable;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic [2:0]  evt_count;

  always #5 clk = ~clk;

  key_scan #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_stable (sw_stable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_count (evt_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] hist[$];      // sw as sampled at each rising edge since reset
  logic [15:0] m_stable;
  logic [15:0] m_pending;
  int          m_last_flip[16];
  logic [4:0]  exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic samp(int j, int i);
    if (j < 0) return 1'b0;
    return hist[j][i];
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_stable  = '0;
    m_pending = '0;
    for (int i = 0; i < 16; i++) m_last_flip[i] = -1000;
  endtask

  // One rising edge. A channel flips when the last DC synchronized samples
  // (the synchronizer delays sw by two edges) all disagree with the stable
  // level and at least DC edges have passed since its previous flip.
  task automatic model_edge();
    int t;
    bit all_diff;
    hist.push_back(sw);
    t = hist.size() - 1;
    if (exp_q.size() != 0 && evt_ready) void'(exp_q.pop_front());
    if (m_pending != '0 && exp_q.size() < 4) begin
      for (int i = 0; i < 16; i++) begin
        if (m_pending[i]) begin
          exp_q.push_back({(REL ? m_stable[i] : 1'b1), 4'(i)});
          m_pending[i] = 1'b0;
          break;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (t - m_last_flip[i] >= DC) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (samp(t - 2 - k, i) == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i]    = ~m_stable[i];
          m_last_flip[i] = t;
          if (REL || m_stable[i]) m_pending[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("sw_stable", sw_stable, m_stable);
    chk("evt_count", 16'(evt_count), 16'(exp_q.size()));
    chk("evt_valid", 16'(evt_valid), 16'(exp_q.size() != 0));
    chk("evt_data", 16'(evt_data), (exp_q.size() != 0) ? 16'(exp_q[0]) : 16'h0);
  endtask

  // driver: inputs are set by the caller away from the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [4:0] got[$];
  logic [4:0] exp6 [6];
  int         b;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sw_stable", sw_stable, 16'h0);
    chk("rst_evt_valid", 16'(evt_valid), 16'h0);
    chk("rst_evt_data", 16'(evt_data), 16'h0);
    chk("rst_evt_count", 16'(evt_count), 16'h0);
    #2 rst_n = 1'b1;

    // single press: stable after DC+2 edges, event one edge later
    sw[3] = 1'b1;
    ticks(9);
    chk("press_not_yet", 16'(sw_stable[3]), 16'h0);
    tick();
    chk("press_stable", 16'(sw_stable[3]), 16'h1);
    tick();
    chk("press_valid", 16'(evt_valid), 16'h1);
    chk("press_data", 16'(evt_data), 16'h13);
    evt_ready = 1'b1;
    ticks(2);
    evt_ready = 1'b0;

    // glitch shorter than DC is ignored
    sw[5] = 1'b1;
    ticks(5);
    sw[5] = 1'b0;
    ticks(15);
    chk("glitch_stable", 16'(sw_stable[5]), 16'h0);
    chk("glitch_count", 16'(evt_count), 16'h0);

    // three simultaneous presses stream out in index order
    evt_ready = 1'b1;
    sw[0] = 1'b1; sw[7] = 1'b1; sw[15] = 1'b1;
    ticks(11);
    chk("multi_0", 16'(evt_data), 16'h10);
    tick();
    chk("multi_7", 16'(evt_data), 16'h17);
    tick();
    chk("multi_15", 16'(evt_data), 16'h1F);
    tick();
    chk("multi_empty", 16'(evt_count), 16'h0);

    // six presses with a stalled consumer: FIFO fills, rest stay pending
    evt_ready = 1'b0;
    sw[1] = 1'b1; sw[4] = 1'b1; sw[6] = 1'b1;
    sw[9] = 1'b1; sw[11] = 1'b1; sw[14] = 1'b1;
    ticks(16);
    chk("full_count", 16'(evt_count), 16'h4);
    exp6[0] = 5'h11; exp6[1] = 5'h14; exp6[2] = 5'h16;
    exp6[3] = 5'h19; exp6[4] = 5'h1B; exp6[5] = 5'h1E;
    evt_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (evt_valid) got.push_back(evt_data);
      tick();
    end
    chk("drain_n", 16'(got.size()), 16'h6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) chk($sformatf("drain_%0d", k), 16'(got[k]), 16'(exp6[k]));
    end
    chk("drain_count", 16'(evt_count), 16'h0);

    // release of channel 2
    sw[2] = 1'b1;
    ticks(14);
    evt_ready = 1'b0;
    sw[2] = 1'b0;
    ticks(11);
    chk("release_valid", 16'(evt_valid), 16'(REL));
    chk("release_data", 16'(evt_data), REL ? 16'h02 : 16'h0);
    evt_ready = 1'b1;
    ticks(3);

    // reset mid-operation with three queued events
    evt_ready = 1'b0;
    sw[10] = 1'b1; sw[12] = 1'b1; sw[13] = 1'b1;
    ticks(14);
    chk("preq_count", 16'(evt_count), 16'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 16'(evt_valid), 16'h0);
    chk("midrst_count", 16'(evt_count), 16'h0);
    chk("midrst_stable", sw_stable, 16'h0);
    chk("midrst_data", 16'(evt_data), 16'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // switches held high across reset release are reported as presses
    ticks(9);
    chk("relhigh_early", sw_stable, 16'h0);
    tick();
    chk("relhigh_stable", sw_stable, sw);
    tick();
    chk("relhigh_first", 16'(evt_data), 16'h10);
    evt_ready = 1'b1;
    ticks(20);

    // random switch activity, mostly-ready consumer
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 15);
        sw[b] = ~sw[b];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    // random activity with a mostly-stalled consumer (full FIFO, coalescing)
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 6) == 0) begin
        b = $urandom_range(0, 15);
        sw[b] = ~sw[b];
      end
      evt_ready = ($urandom_range(0, 5) == 0);
      tick();
    end
    evt_ready = 1'b1;
    ticks(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
